// File: rtl/bram_score_reader_pkg.sv
// Definitions shared by the random-walk engine and the score reader:
// parameter defaults, FSM state encoding and the saturating adder.
package rw_pkg;

    localparam int DEF_ADDR_WIDTH       = 13;
    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_NEI_TABLE_OFFSET = 100;
    localparam int DEF_MAX_STEPS        = 6;
    localparam int DEF_NODE_NUM         = 100;
    localparam int DEF_SEED_NUM         = 10;

    // Address distance between the counter blocks of consecutive nodes.
    localparam int NODE_STRIDE = DEF_MAX_STEPS * DEF_NODE_NUM;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_EMIT = 3'd4,
        ST_FIN  = 3'd5
    } rd_state_e;

    // Unsigned add clamped to 2^width-1; operands wider than width are not expected.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [63:0] lim;
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/bram_score_reader_if.sv
// Result stream of the score reader: (node, score) pairs with valid/ready.
interface bram_score_reader_if
    import rw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_node;
    logic [DATA_WIDTH-1:0] out_score;

    modport master (output out_valid, output out_node, output out_score, input out_ready);
    modport slave  (input out_valid, input out_node, input out_score, output out_ready);
endinterface

// File: rtl/bram_score_reader.sv
// Sums one seed's per-step visit counters per node out of the shared BRAM and
// streams (node, score); owns the bus only while ready is low.
module bram_score_reader
    import rw_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int NEI_TABLE_OFFSET = DEF_NEI_TABLE_OFFSET,
    parameter int MAX_STEPS        = DEF_MAX_STEPS,
    parameter int NODE_NUM         = DEF_NODE_NUM,
    parameter int SEED_NUM         = DEF_SEED_NUM,
    parameter int CLEAR_ON_READ    = 0,
    parameter int SKIP_ZERO        = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  ready,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed_index,
    output wire  [ADDR_WIDTH-1:0] address,
    output wire                   write_enable,
    output wire  [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    bram_score_reader_if.master   res
);

    localparam int STRIDE = MAX_STEPS * NODE_NUM;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [STEP_W-1:0]     T_LAST   = STEP_W'(MAX_STEPS);
    localparam logic [DATA_WIDTH-1:0] N_LAST   = DATA_WIDTH'(NODE_NUM);
    localparam logic [DATA_WIDTH-1:0] S_LAST   = DATA_WIDTH'(SEED_NUM);
    // From a node's last step address to the next node's first step address.
    localparam logic [ADDR_WIDTH-1:0] NODE_HOP = ADDR_WIDTH'(STRIDE - MAX_STEPS + 1);

    function automatic logic [DATA_WIDTH-1:0] acc_sat(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        return DATA_WIDTH'(sat_add(64'(a), 64'(b), DATA_WIDTH));
    endfunction

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] n_q, n_d;
    logic [STEP_W-1:0]     t_q, t_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  emit_vld;
    logic                  step_done;
    logic                  seed_ok;
    logic [ADDR_WIDTH-1:0] start_addr;

    assign emit_vld = (state_q == ST_EMIT) && !((SKIP_ZERO != 0) && (acc_q == '0));
    assign seed_ok  = (seed_index != '0) && (seed_index <= S_LAST);
    // First counter of node 1: the node-1 stride is folded into the constant part.
    assign start_addr = ADDR_WIDTH'(32'(NEI_TABLE_OFFSET + STRIDE + 1)
                        + 32'(seed_index - DATA_WIDTH'(1)) * 32'(MAX_STEPS));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        n_d       = n_q;
        t_d       = t_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        step_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!ready && seed_ok) begin
                        state_d = ST_RD;
                        addr_d  = start_addr;
                        n_d     = DATA_WIDTH'(1);
                        t_d     = STEP_W'(1);
                        acc_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RD:  state_d = ST_CAP;
            ST_CAP: begin
                acc_d = acc_sat(acc_q, data_in);
                if (CLEAR_ON_READ != 0) state_d = ST_WR;
                else                    step_done = 1'b1;
            end
            ST_WR:  step_done = 1'b1;
            ST_EMIT: begin
                if (!emit_vld || res.out_ready) begin
                    if (n_q < N_LAST) begin
                        state_d = ST_RD;
                        n_d     = n_q + DATA_WIDTH'(1);
                        t_d     = STEP_W'(1);
                        acc_d   = '0;
                        addr_d  = addr_q + NODE_HOP;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (step_done) begin
            if (t_q < T_LAST) begin
                state_d = ST_RD;
                t_d     = t_q + STEP_W'(1);
                addr_d  = addr_q + ADDR_WIDTH'(1);
            end else begin
                state_d = ST_EMIT;
            end
        end

        // Engine reclaimed the bus mid-readout: drop everything, report it.
        if (ready && busy_q && (state_q != ST_FIN)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            n_q     <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign address      = ready ? 'z   : addr_q;
    assign write_enable = ready ? 1'bz : (state_q == ST_WR);
    assign data_out     = ready ? 'z   : '0;

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign res.out_valid = emit_vld;
    assign res.out_node  = n_q;
    assign res.out_score = acc_q;

endmodule

// File: tb/tb_bram_score_reader.sv
// Directed bench: two readers (plain and clear-on-read) on private BRAM models.
module tb_bram_score_reader;

    localparam int AW = 13;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst, start0, start1, ready0, ready1;
    logic [DW-1:0] seed;
    wire  [AW-1:0] addr0, addr1;
    wire           we0, we1;
    wire  [DW-1:0] dout0, dout1;
    logic [DW-1:0] din0, din1;
    logic          busy0, done0, err0, busy1, done1, err1;

    bram_score_reader_if #(.DATA_WIDTH(DW)) if0 ();
    bram_score_reader_if #(.DATA_WIDTH(DW)) if1 ();

    bram_score_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NEI_TABLE_OFFSET(100), .MAX_STEPS(2),
        .NODE_NUM(3), .SEED_NUM(2), .CLEAR_ON_READ(0), .SKIP_ZERO(1)) dut0 (
        .clk(clk), .arst(arst), .ready(ready0), .start(start0), .seed_index(seed),
        .address(addr0), .write_enable(we0), .data_out(dout0), .data_in(din0),
        .busy(busy0), .done(done0), .err(err0), .res(if0));

    bram_score_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NEI_TABLE_OFFSET(100), .MAX_STEPS(2),
        .NODE_NUM(3), .SEED_NUM(2), .CLEAR_ON_READ(1), .SKIP_ZERO(1)) dut1 (
        .clk(clk), .arst(arst), .ready(ready1), .start(start1), .seed_index(seed),
        .address(addr1), .write_enable(we1), .data_out(dout1), .data_in(din1),
        .busy(busy1), .done(done1), .err(err1), .res(if1));

    // BRAM models with one-cycle read latency plus a bench-side preload port.
    logic [DW-1:0] mem0 [0:8191];
    logic [DW-1:0] mem1 [0:8191];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem0[pl_addr] <= pl_data;
            mem1[pl_addr] <= pl_data;
        end
        if (!ready0 && we0) mem0[addr0] <= dout0;
        if (!ready1 && we1) mem1[addr1] <= dout1;
        din0 <= mem0[addr0];
        din1 <= mem1[addr1];
    end

    int            n_done0 = 0, n_err0 = 0, n_wr0 = 0, bcyc0 = 0;
    int            n_done1 = 0, n_wr1 = 0, n_wbad1 = 0, bcyc1 = 0;
    int unsigned   q_node0 [$], q_score0 [$], q_node1 [$], q_score1 [$];
    int unsigned   q_waddr1 [$];

    always @(posedge clk) begin
        if (if0.out_valid && if0.out_ready) begin
            q_node0.push_back(if0.out_node);
            q_score0.push_back(if0.out_score);
        end
        if (if1.out_valid && if1.out_ready) begin
            q_node1.push_back(if1.out_node);
            q_score1.push_back(if1.out_score);
        end
        if (!ready0 && we0) n_wr0 <= n_wr0 + 1;
        if (!ready1 && we1) begin
            n_wr1 <= n_wr1 + 1;
            q_waddr1.push_back(int'(addr1));
            if (dout1 != '0) n_wbad1 <= n_wbad1 + 1;
        end
        if (done0) n_done0 <= n_done0 + 1;
        if (done1) n_done1 <= n_done1 + 1;
        if (err0)  n_err0  <= n_err0 + 1;
        if (busy0) bcyc0   <= bcyc0 + 1;
        if (busy1) bcyc1   <= bcyc1 + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int unsigned a, input logic [DW-1:0] d);
        pl_addr = AW'(a);
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic pulse_start(input int which, input logic [DW-1:0] s);
        seed = s;
        if (which == 0) start0 = 1'b1;
        else            start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((which == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_pair(input string tag, input int which, input int idx,
                              input int unsigned node, input int unsigned score);
        int unsigned gn, gs;
        gn = 0;
        gs = 0;
        if (which == 0 && idx < q_node0.size()) begin
            gn = q_node0[idx];
            gs = q_score0[idx];
        end
        if (which == 1 && idx < q_node1.size()) begin
            gn = q_node1[idx];
            gs = q_score1[idx];
        end
        check(tag, {gn, gs}, {node, score});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int unsigned pa [6];
    int unsigned pd [6];
    int          b, c, d, e, w, seen;

    initial begin
        pa = '{109, 110, 115, 116, 121, 122};
        pd = '{3, 4, 0, 0, 1, 0};
        arst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
        seed = 2; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_busy",  {busy0, busy1}, 0);
        check("rst_flags", {done0, err0, done1, err1}, 0);
        check("rst_valid", {if0.out_valid, if1.out_valid}, 0);
        check("rst_result", {if0.out_node, if0.out_score}, 0);

        arst = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        @(negedge clk);
        check("idle_bus", {addr0, we0, dout0}, 0);
        for (int k = 0; k < 6; k++) preload(pa[k], pd[k]);

        // Basic readout, no clearing.
        b = q_node0.size(); c = bcyc0; d = n_done0; e = n_err0; w = n_wr0;
        pulse_start(0, 2);
        wait_done(0, "basic_done_seen");
        check("basic_count", 64'(q_node0.size() - b), 2);
        check_pair("basic_r0", 0, b, 1, 7);
        check_pair("basic_r1", 0, b + 1, 3, 1);
        check("basic_done_cnt", 64'(n_done0 - d), 1);
        check("basic_no_err", 64'(n_err0 - e), 0);
        check("basic_no_write", 64'(n_wr0 - w), 0);
        check("basic_cycles", 64'(bcyc0 - c), 16);
        check("basic_idle", {busy0, if0.out_valid}, 0);

        // Clear on read.
        b = q_node1.size(); c = bcyc1; d = n_done1; w = n_wr1;
        pulse_start(1, 2);
        wait_done(1, "clr_done_seen");
        check("clr_count", 64'(q_node1.size() - b), 2);
        check_pair("clr_r0", 1, b, 1, 7);
        check_pair("clr_r1", 1, b + 1, 3, 1);
        check("clr_done_cnt", 64'(n_done1 - d), 1);
        check("clr_writes", 64'(n_wr1 - w), 6);
        check("clr_wdata", 64'(n_wbad1), 0);
        check("clr_cycles", 64'(bcyc1 - c), 22);
        for (int k = 0; k < 6; k++) begin
            check("clr_waddr", 64'((w + k < q_waddr1.size()) ? q_waddr1[w + k] : 0), 64'(pa[k]));
            check("clr_mem_zero", 64'(mem1[pa[k]]), 0);
        end

        // Back-pressure at node 1.
        b = q_node0.size();
        if0.out_ready = 1'b0;
        pulse_start(0, 2);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (if0.out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("bp_valid_seen", 64'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {if0.out_valid, if0.out_node[15:0], if0.out_score, addr0, we0},
                  {1'b1, 16'd1, 32'd7, 13'd110, 1'b0});
            @(negedge clk);
        end
        check("bp_no_xfer", 64'(q_node0.size() - b), 0);
        if0.out_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer", 64'(q_node0.size() - b), 1);
        check_pair("bp_r0", 0, b, 1, 7);
        check("bp_next", {if0.out_valid, if0.out_node}, {1'b0, 32'd2});
        wait_done(0, "bp_done_seen");
        check_pair("bp_r1", 0, b + 1, 3, 1);

        // Saturation, plus a start while busy that must be ignored.
        preload(109, 32'hFFFF_FFFF);
        preload(110, 32'd5);
        b = q_node0.size(); d = n_done0; e = n_err0;
        pulse_start(0, 2);
        @(negedge clk);
        pulse_start(0, 2);
        check("busy_start_noerr", {err0, busy0}, 2'b01);
        wait_done(0, "sat_done_seen");
        check_pair("sat_r0", 0, b, 1, 32'hFFFF_FFFF);
        check_pair("sat_r1", 0, b + 1, 3, 1);
        check("sat_done_cnt", 64'(n_done0 - d), 1);
        check("sat_no_err", 64'(n_err0 - e), 0);

        // Abort during node 2 CAP (cycle 7 after the accepting edge).
        preload(109, 32'd3);
        preload(110, 32'd4);
        b = q_node0.size(); d = n_done0; e = n_err0;
        pulse_start(0, 2);
        repeat (6) @(negedge clk);
        check("abort_at_node2", {if0.out_node, if0.out_valid, busy0}, {32'd2, 1'b0, 1'b1});
        ready0 = 1'b1;
        @(negedge clk);
        check("abort_err", {err0, busy0, if0.out_valid, done0}, 4'b1000);
        @(negedge clk);
        check("abort_err_pulse", {err0, busy0}, 0);
        ready0 = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_emits", 64'(q_node0.size() - b), 1);
        check("abort_no_done", 64'(n_done0 - d), 0);
        check("abort_err_cnt", 64'(n_err0 - e), 1);

        // Rejected starts.
        e = n_err0;
        pulse_start(0, 0);
        check("rej_seed0", {err0, busy0}, 2'b10);
        @(negedge clk);
        pulse_start(0, 3);
        check("rej_seed3", {err0, busy0}, 2'b10);
        @(negedge clk);
        ready0 = 1'b1;
        pulse_start(0, 2);
        check("rej_not_owner", {err0, busy0}, 2'b10);
        ready0 = 1'b0;
        @(negedge clk);
        check("rej_err_cnt", 64'(n_err0 - e), 3);

        // Asynchronous reset with dut0 held in EMIT and dut1 in WR.
        if0.out_ready = 1'b0;
        seed = 2; start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_arst", {if0.out_valid, we1, busy0, busy1}, 4'b1111);
        arst = 1'b1;
        #1;
        check("arst_async", {if0.out_valid, busy0, busy1, we1, we0}, 0);
        check("arst_result", {if0.out_node, if0.out_score}, 0);
        @(negedge clk);
        arst = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        check("post_arst_idle", {busy0, busy1, done0, done1, if0.out_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
